// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the operation is split into STAGES
// ripple chunks with registered inter-chunk carries; a single stall freezes every stage.
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic              ovf_q;
  logic              ovf_d;

  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  r_in  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;
  logic [CW:0]       chunk [STAGES];
  logic              stall;

  assign stall     = valid_q[LAST] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_q[LAST];
  assign sum       = res_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;

  // Stage inputs: ports (with operand prep) feed stage 0, stage k-1 registers feed stage k.
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    r_in[0] = '0;
    c_in[0] = sub | cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      r_in[k] = res_q[k-1];
      c_in[k] = carry_q[k-1];
      v_in[k] = valid_q[k-1];
    end
  end

  // Each stage ripples its own chunk and merges it into the partial result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk[k]             = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                             + {{CW{1'b0}}, c_in[k]};
      res_d[k]             = r_in[k];
      res_d[k][k*CW +: CW] = chunk[k][CW-1:0];
      carry_d[k]           = chunk[k][CW];
      a_d[k]               = a_in[k];
      b_d[k]               = b_in[k];
      valid_d[k]           = v_in[k];
    end
    ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
            (res_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (!stall) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: STAGES=4 main instance plus STAGES=1 and
// STAGES=16 instances sharing stimulus, each with its own in-order scoreboard.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic [17:0] cur_exp;

  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [15:0] sum4;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] q4[$];
  logic [17:0] q1[$];
  logic [17:0] q16[$];
  logic [17:0] h4, h1, h16;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  pipelined_add_sub #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  pipelined_add_sub #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-computed vectors; cur_exp = {ovf, cout, sum}.
  task automatic set_vec(input int i);
    case (i)
      0:       begin a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; cur_exp = {2'b00, 16'h0100}; end
      1:       begin a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b0; cur_exp = {2'b01, 16'h0000}; end
      2:       begin a = 16'h7FFF; b = 16'h0000; sub = 1'b0; cin = 1'b1; cur_exp = {2'b10, 16'h8000}; end
      3:       begin a = 16'h0005; b = 16'h0007; sub = 1'b1; cin = 1'b1; cur_exp = {2'b00, 16'hFFFE}; end
      4:       begin a = 16'h8000; b = 16'h0001; sub = 1'b1; cin = 1'b0; cur_exp = {2'b11, 16'h7FFF}; end
      5:       begin a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; cur_exp = {2'b00, 16'h5555}; end
      6:       begin a = 16'h1234; b = 16'h1234; sub = 1'b1; cin = 1'b0; cur_exp = {2'b01, 16'h0000}; end
      7:       begin a = 16'h8000; b = 16'h8000; sub = 1'b0; cin = 1'b0; cur_exp = {2'b11, 16'h0000}; end
      8:       begin a = 16'h0F0F; b = 16'hF0F0; sub = 1'b0; cin = 1'b1; cur_exp = {2'b01, 16'h0000}; end
      9:       begin a = 16'h7FFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; cur_exp = {2'b10, 16'h8000}; end
      10:      begin a = 16'hABCD; b = 16'h0000; sub = 1'b0; cin = 1'b1; cur_exp = {2'b00, 16'hABCE}; end
      11:      begin a = 16'h0000; b = 16'h0000; sub = 1'b1; cin = 1'b0; cur_exp = {2'b01, 16'h0000}; end
      default: begin a = 16'hFFFF; b = 16'h0001; sub = 1'b1; cin = 1'b0; cur_exp = {2'b01, 16'hFFFE}; end
    endcase
  endtask

  // Presents vector i and returns just after the edge where the STAGES=4 instance takes it.
  task automatic send(input int i);
    int guard;
    guard = 0;
    set_vec(i);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready4) check_eq("send_timeout", 32'(in_ready4), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (24) @(posedge clk);
    #1;
  endtask

  // Transfers happen at the next rising edge; record/compare them here.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      q1.delete();
      q16.delete();
    end else begin
      if (in_valid && in_ready4)  q4.push_back(cur_exp);
      if (in_valid && in_ready1)  q1.push_back(cur_exp);
      if (in_valid && in_ready16) q16.push_back(cur_exp);
      if (out_valid4 && out_ready) begin
        check_eq("d4_expected_pending", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) check_eq("d4_result", 32'({ovf4, cout4, sum4}), 32'(q4.pop_front()));
      end
      if (out_valid1 && out_ready) begin
        check_eq("d1_expected_pending", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) check_eq("d1_result", 32'({ovf1, cout1, sum1}), 32'(q1.pop_front()));
      end
      if (out_valid16 && out_ready) begin
        check_eq("d16_expected_pending", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) check_eq("d16_result", 32'({ovf16, cout16, sum16}), 32'(q16.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_vec(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid4", 32'(out_valid4), 32'd0);
    check_eq("rst_sum4", 32'(sum4), 32'd0);
    check_eq("rst_cout4", 32'(cout4), 32'd0);
    check_eq("rst_ovf4", 32'(ovf4), 32'd0);
    check_eq("rst_in_ready4", 32'(in_ready4), 32'd1);
    check_eq("rst_out_valid1", 32'(out_valid1), 32'd0);
    check_eq("rst_out_valid16", 32'(out_valid16), 32'd0);
    @(posedge clk);
    #1;

    // Latency: accepted at E, visible right after E+3.
    send(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("lat_early_valid", 32'(out_valid4), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(out_valid4), 32'd1);
    check_eq("lat_sum", 32'(sum4), 32'h0100);
    check_eq("lat_cout", 32'(cout4), 32'd0);
    check_eq("lat_ovf", 32'(ovf4), 32'd0);
    drain();

    // Carry propagation and subtract corner cases.
    for (int i = 1; i <= 4; i++) send(i);
    drain();

    // Back-to-back streaming of eight operations.
    fork
      begin
        for (int i = 5; i <= 12; i++) send(i);
      end
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("stream_early_valid", 32'(out_valid4), 32'd0);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          check_eq("stream_valid", 32'(out_valid4), 32'd1);
        end
      end
    join
    drain();

    // Backpressure: fill every instance, then hold out_ready low with input pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_vec(1 + (i % 12));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    h4  = {ovf4, cout4, sum4};
    h1  = {ovf1, cout1, sum1};
    h16 = {ovf16, cout16, sum16};
    check_eq("bp_head4", 32'(h4), 32'h10000);
    check_eq("bp_head1", 32'(h1), 32'h10000);
    check_eq("bp_head16", 32'(h16), 32'h10000);
    for (int j = 0; j < 3; j++) begin
      if (j != 0) @(negedge clk);
      check_eq("bp_in_ready4", 32'(in_ready4), 32'd0);
      check_eq("bp_in_ready1", 32'(in_ready1), 32'd0);
      check_eq("bp_in_ready16", 32'(in_ready16), 32'd0);
      check_eq("bp_out_valid16", 32'(out_valid16), 32'd1);
      if (j != 0) begin
        check_eq("bp_hold4", 32'({ovf4, cout4, sum4}), 32'(h4));
        check_eq("bp_hold1", 32'({ovf1, cout1, sum1}), 32'(h1));
        check_eq("bp_hold16", 32'({ovf16, cout16, sum16}), 32'(h16));
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_vec(i + 5);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check_eq("bp_drain4", 32'(q4.size()), 32'd0);
    check_eq("bp_drain1", 32'(q1.size()), 32'd0);
    check_eq("bp_drain16", 32'(q16.size()), 32'd0);

    // Reset with three operations in flight and a simultaneous input.
    send(5);
    send(6);
    send(7);
    set_vec(8);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid4", 32'(out_valid4), 32'd0);
    check_eq("mid_rst_sum4", 32'(sum4), 32'd0);
    check_eq("mid_rst_cout4", 32'(cout4), 32'd0);
    check_eq("mid_rst_ovf4", 32'(ovf4), 32'd0);
    check_eq("mid_rst_in_ready4", 32'(in_ready4), 32'd1);
    check_eq("mid_rst_out_valid1", 32'(out_valid1), 32'd0);
    check_eq("mid_rst_out_valid16", 32'(out_valid16), 32'd0);
    @(posedge clk);
    #1;
    send(10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_early_valid", 32'(out_valid4), 32'd0);
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid4), 32'd1);
    check_eq("post_rst_sum", 32'(sum4), 32'hABCE);
    drain();
    check_eq("end_drain4", 32'(q4.size()), 32'd0);
    check_eq("end_drain1", 32'(q1.size()), 32'd0);
    check_eq("end_drain16", 32'(q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

- Parametrised, pipelined two's-complement adder/subtractor.
- Splits a `WIDTH`-bit operation into `STAGES` equal chunks and registers the inter-chunk carry at each stage boundary. Throughput is one operation per cycle; latency is `STAGES` cycles.
- Carries a valid/ready handshake on input and output, a per-operation add/subtract mode, and carry-out and signed-overflow flags.
- Intended for datapaths where a full-width combinational ripple chain cannot meet timing.

## Interface

Parameters:
- `WIDTH`, 16 — operand/result width. Must be divisible by `STAGES`.
- `STAGES`, 4 — number of pipeline stages, 1..`WIDTH`. Chunk width `CW = WIDTH/STAGES`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1 — clock. All state updates on its rising edge.
- `rst`  in  1 — synchronous, active-high reset.
- `in_valid`  in  1 — input operation present.
- `in_ready`  out  1 — block can accept an operation this cycle.
- `a`  in  `WIDTH` — operand A.
- `b`  in  `WIDTH` — operand B.
- `sub`  in  1 — 1 means A−B, 0 means A+B+`cin`.
- `cin`  in  1 — carry-in for add. Ignored when `sub`=1.
- `out_valid`  out  1 — result present.
- `out_ready`  in  1 — downstream accepts result.
- `sum`  out  `WIDTH` — result.
- `cout`  out  1 — carry out of bit `WIDTH-1`. For subtract, 1 means no borrow.
- `ovf`  out  1 — signed overflow.

## Operation

Operand preparation:
- `b_eff = sub ? ~b : b`.
- `c0 = sub ? 1 : cin`.
- Result is `a + b_eff + c0`, computed `WIDTH+1` bits wide. `sum` is the low `WIDTH` bits; `cout` is bit `WIDTH`.

Stage k (0..STAGES-1):
- Adds chunk k of `a` and `b_eff` plus the carry registered from stage k−1 (stage 0 uses `c0`).
- Registers: the result chunk, the carry, the already-computed lower result chunks, and the not-yet-used upper operand chunks.

Overflow:
- Stage STAGES−1 computes `ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1])`.
- Operand sign bits travel with the data to feed this.

Valid pipeline:
- One valid bit per stage. `out_valid` is the last stage's valid bit.
- Bubbles are not collapsed: an empty stage advances like a full one.

Handshake:
- `stall = out_valid && !out_ready`.
- `in_ready = !stall`. This is combinational from `out_valid`/`out_ready` only; it never depends on `in_valid`.
- When `stall`=1, every stage register holds, including valids. `sum`, `cout` and `ovf` stay stable.
- When `stall`=0, every stage advances. Stage 0 loads `in_valid` and the new operand.
- A transfer occurs on the input when `in_valid && in_ready`, and on the output when `out_valid && out_ready`.
- Results leave in acceptance order: no reordering, drop or duplication.

Reset:
- All valid bits clear. `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- `in_ready`=1 after reset, since `out_valid`=0.
- Reset mid-operation discards every in-flight operation. Reset takes priority over stall and over any simultaneous input.

## Timing

- Latency: an operation accepted at rising edge E appears on `out_*` with `out_valid`=1 immediately after edge E+STAGES−1, provided there is no stall. With `STAGES`=1, the result is registered at the acceptance edge.
- Throughput: one operation per cycle when `out_ready` is held at 1.
- Backpressure: a result is presented, `out_ready`=0, and the pipeline is full. No new input is accepted until the cycle `out_ready`=1. Acceptance and output transfer may occur in that same cycle.
- Critical path: one `CW`-bit ripple chunk plus operand muxing (stage 0) or the overflow logic (last stage).
- `sum`, `cout` and `ovf` are only meaningful while `out_valid`=1. Between results they hold the last value or a bubble's data.

## Test plan

Bench configuration: `WIDTH`=16, `STAGES`=4 unless noted.

1. Add 0x00FF + 0x0001 with `cin`=0, accepted at edge E → after edge E+3: `sum`=0x0100, `cout`=0, `ovf`=0, `out_valid`=1.
2. Full carry propagation:
   - 0xFFFF + 0x0001 → `sum`=0x0000, `cout`=1, `ovf`=0.
   - 0x7FFF + 0x0000 with `cin`=1 → `sum`=0x8000, `ovf`=1.
3. Subtract:
   - 0x0005 − 0x0007 (`cin`=1, ignored) → `sum`=0xFFFE, `cout`=0, `ovf`=0.
   - 0x8000 − 0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
4. Streaming: 8 back-to-back random add/sub operations with `out_ready`=1 → 8 consecutive results in order, each matching the reference model, first result 4 cycles after first acceptance.
5. Backpressure: fill the pipeline, then hold `out_ready`=0 for 3 cycles while `in_valid`=1 →
   - `in_ready`=0 for those cycles.
   - `sum`/`cout`/`ovf` stable.
   - After release, all results delivered exactly once, in order.
   - Repeat with `STAGES`=1 and `STAGES`=16.
6. Assert `rst` for one cycle with 3 operations in flight → next cycle `out_valid`=0, outputs 0, `in_ready`=1. No pre-reset result ever appears; a post-reset operation completes with 4-cycle latency.
